alu_muldiv: RTL and testbench

ALU_MULDIV -- requirements
Module: alu_muldiv

---
 rtl/alu_muldiv_pkg.sv | 23 ++
 rtl/alu_muldiv_ctrl.sv | 74 +++++++
 rtl/alu_muldiv.sv | 135 +++++++++++++
 tb/tb_alu_muldiv.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_muldiv_pkg.sv
// Shared encodings and defaults for the iterative RV32M multiply/divide unit.
package alu_muldiv_pkg;

   localparam int unsigned IterDefault = 32;
   localparam int unsigned CntW        = 5;

   localparam logic [2:0] OpMul    = 3'b000;
   localparam logic [2:0] OpMulh   = 3'b001;
   localparam logic [2:0] OpMulhsu = 3'b010;
   localparam logic [2:0] OpMulhu  = 3'b011;
   localparam logic [2:0] OpDiv    = 3'b100;
   localparam logic [2:0] OpDivu   = 3'b101;
   localparam logic [2:0] OpRem    = 3'b110;
   localparam logic [2:0] OpRemu   = 3'b111;

   typedef enum logic [1:0] {
      StIdle,
      StCalc,
      StFix,
      StDone
   } state_e;

endpackage

// File: rtl/alu_muldiv_ctrl.sv
// Sequencing FSM and iteration counter for alu_muldiv; busy/done are registered.
module alu_muldiv_ctrl
   import alu_muldiv_pkg::*;
#(
   parameter int unsigned ITER = IterDefault
) (
   input  logic i_clk,
   input  logic i_rstn,
   input  logic i_start,
   input  logic i_flush,
   input  logic i_special,
   output logic o_accept,
   output logic o_calc,
   output logic o_fix,
   output logic o_busy,
   output logic o_done
);

   state_e          r_state;
   logic [CntW-1:0] r_cnt;
   logic            r_busy;
   logic            r_done;
   logic            w_can_start;

   assign w_can_start = (r_state == StIdle) || (r_state == StDone);
   assign o_accept    = w_can_start && i_start && !i_flush;
   assign o_calc      = (r_state == StCalc);
   assign o_fix       = (r_state == StFix);
   assign o_busy      = r_busy;
   assign o_done      = r_done;

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_state <= StIdle;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else if (i_flush) begin
         r_state <= StIdle;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         unique case (r_state)
            StIdle, StDone: begin
               r_done <= 1'b0;
               r_cnt  <= '0;
               if (i_start) begin
                  r_busy  <= 1'b1;
                  r_state <= i_special ? StFix : StCalc;
               end else begin
                  r_busy  <= 1'b0;
                  r_state <= StIdle;
               end
            end
            StCalc: begin
               if (r_cnt == CntW'(ITER - 1)) begin
                  r_cnt   <= '0;
                  r_state <= StFix;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            StFix: begin
               r_state <= StDone;
               r_busy  <= 1'b0;
               r_done  <= 1'b1;
            end
            default: r_state <= StIdle;
         endcase
      end
   end

endmodule

// File: rtl/alu_muldiv.sv
// Iterative RV32M multiply/divide: shift-add multiply and restoring divide on
// operand magnitudes, with sign correction applied in the FIX cycle.
module alu_muldiv
   import alu_muldiv_pkg::*;
#(
   parameter int unsigned XLEN = 32,
   parameter int unsigned ITER = IterDefault
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            start,
   input  logic            flush,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] ALUData1,
   input  logic [XLEN-1:0] ALUData2,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

   logic [2:0]        r_op;
   logic              r_neg;
   logic [XLEN-1:0]   r_mcand;
   logic [2*XLEN-1:0] r_prod;
   logic [XLEN-1:0]   r_result;

   logic              w_accept, w_calc, w_fix;
   logic              w_is_div, w_sgn_a, w_sgn_b, w_neg;
   logic              w_div0, w_ovf, w_special;
   logic [XLEN-1:0]   w_mag_a, w_mag_b, w_spec_res;
   logic [XLEN:0]     w_sum, w_shl, w_diff;
   logic [2*XLEN-1:0] w_step, w_prod_neg;
   logic [XLEN-1:0]   w_fix_res;

   alu_muldiv_ctrl #(
      .ITER (ITER)
   ) u_ctrl (
      .i_clk     (clk),
      .i_rstn    (rstn),
      .i_start   (start),
      .i_flush   (flush),
      .i_special (w_special),
      .o_accept  (w_accept),
      .o_calc    (w_calc),
      .o_fix     (w_fix),
      .o_busy    (busy),
      .o_done    (done)
   );

   always_comb begin
      w_sgn_a = 1'b0;
      w_sgn_b = 1'b0;
      case (op)
         OpMulh, OpDiv, OpRem: begin
            w_sgn_a = ALUData1[XLEN-1];
            w_sgn_b = ALUData2[XLEN-1];
         end
         OpMulhsu: w_sgn_a = ALUData1[XLEN-1];
         default: ;
      endcase
      w_is_div = op[2];
      w_mag_a  = w_sgn_a ? -ALUData1 : ALUData1;
      w_mag_b  = w_sgn_b ? -ALUData2 : ALUData2;
      // Remainders take the dividend's sign; everything else the XOR of signs.
      w_neg    = (op == OpRem) ? w_sgn_a : (w_sgn_a ^ w_sgn_b);
      w_div0   = w_is_div && (ALUData2 == '0);
      w_ovf    = w_is_div && !op[0] && (ALUData1 == MinNeg) && (ALUData2 == '1);
      w_special  = w_div0 || w_ovf;
      w_spec_res = w_div0 ? (op[1] ? ALUData1 : '1) : (op[1] ? '0 : MinNeg);
   end

   // One iteration: low half holds multiplier / dividend bits being consumed.
   always_comb begin
      w_sum  = {1'b0, r_prod[2*XLEN-1:XLEN]} + {1'b0, r_mcand};
      w_shl  = {r_prod[2*XLEN-1:XLEN], r_prod[XLEN-1]};
      w_diff = w_shl - {1'b0, r_mcand};
      if (r_op[2]) begin
         if (!w_diff[XLEN]) w_step = {w_diff[XLEN-1:0], r_prod[XLEN-2:0], 1'b1};
         else               w_step = {w_shl[XLEN-1:0], r_prod[XLEN-2:0], 1'b0};
      end else if (r_prod[0]) begin
         w_step = {w_sum, r_prod[XLEN-1:1]};
      end else begin
         w_step = {1'b0, r_prod[2*XLEN-1:1]};
      end
   end

   always_comb begin
      w_prod_neg = r_neg ? -r_prod : r_prod;
      w_fix_res  = r_prod[XLEN-1:0];
      unique case (r_op)
         OpMul:                     w_fix_res = r_prod[XLEN-1:0];
         OpMulh, OpMulhsu, OpMulhu: w_fix_res = w_prod_neg[2*XLEN-1:XLEN];
         OpDiv, OpDivu:  w_fix_res = r_neg ? -r_prod[XLEN-1:0] : r_prod[XLEN-1:0];
         OpRem, OpRemu:  w_fix_res = r_neg ? -r_prod[2*XLEN-1:XLEN] : r_prod[2*XLEN-1:XLEN];
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_op     <= OpMul;
         r_neg    <= 1'b0;
         r_mcand  <= '0;
         r_prod   <= '0;
         r_result <= '0;
      end else begin
         if (w_accept) begin
            r_op <= op;
            if (w_special) begin
               // Both halves carry the answer so FIX selects it for any op.
               r_neg   <= 1'b0;
               r_mcand <= '0;
               r_prod  <= {w_spec_res, w_spec_res};
            end else if (w_is_div) begin
               r_neg   <= w_neg;
               r_mcand <= w_mag_b;
               r_prod  <= {{XLEN{1'b0}}, w_mag_a};
            end else begin
               r_neg   <= w_neg;
               r_mcand <= w_mag_a;
               r_prod  <= {{XLEN{1'b0}}, w_mag_b};
            end
         end else if (w_calc && !flush) begin
            r_prod <= w_step;
         end
         if (w_fix && !flush) begin
            r_result <= w_fix_res;
         end
      end
   end

   assign result = r_result;

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed vector bench for alu_muldiv: results, latency, busy, flush and reset.
module tb_alu_muldiv;

   localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
   localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

   logic        clk = 1'b0;
   logic        rstn, start, flush;
   logic [2:0]  op;
   logic [31:0] ALUData1, ALUData2;
   logic        busy, done;
   logic [31:0] result;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   alu_muldiv #(
      .XLEN (32),
      .ITER (32)
   ) dut (
      .clk      (clk),
      .rstn     (rstn),
      .start    (start),
      .flush    (flush),
      .op       (op),
      .ALUData1 (ALUData1),
      .ALUData2 (ALUData2),
      .busy     (busy),
      .done     (done),
      .result   (result)
   );

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge just after the accepting edge.
   task automatic accept_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      op = o;
      ALUData1 = a;
      ALUData2 = b;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      op = o ^ 3'b111;
      ALUData1 = ~a;
      ALUData2 = b ^ 32'hA5A5_5A5A;
   endtask

   task automatic wait_done(output logic [31:0] res, output int lat, output int bcnt);
      lat  = -1;
      bcnt = 0;
      res  = 'x;
      for (int k = 0; k < 100; k++) begin
         if (done) begin
            lat = k;
            res = result;
            break;
         end
         if (busy) bcnt++;
         @(negedge clk);
      end
   endtask

   task automatic count_idle(input int n, output int dcnt, output int bcnt);
      dcnt = 0;
      bcnt = 0;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         if (done) dcnt++;
         if (busy) bcnt++;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] res;
      int lat, bc, dc;

      vecs.push_back(vec_t'{MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33});
      vecs.push_back(vec_t'{MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33});
      vecs.push_back(vec_t'{MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33});
      vecs.push_back(vec_t'{MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33});
      vecs.push_back(vec_t'{DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33});
      vecs.push_back(vec_t'{REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33});
      vecs.push_back(vec_t'{DIVU,   32'd100,       32'd7,         32'd14,        33});
      vecs.push_back(vec_t'{REMU,   32'd100,       32'd7,         32'd2,         33});
      vecs.push_back(vec_t'{DIVU,   32'd100,       32'd0,         32'hFFFF_FFFF, 1});
      vecs.push_back(vec_t'{REMU,   32'd100,       32'd0,         32'd100,       1});
      vecs.push_back(vec_t'{DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1});
      vecs.push_back(vec_t'{REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1});
      vecs.push_back(vec_t'{REM,    32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 1});
      vecs.push_back(vec_t'{DIV,    32'd5,         32'd0,         32'hFFFF_FFFF, 1});
      vecs.push_back(vec_t'{MUL,    32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 33});
      vecs.push_back(vec_t'{MULH,   32'hFFFF_FFFF, 32'h0000_0007, 32'hFFFF_FFFF, 33});
      vecs.push_back(vec_t'{MULHSU, 32'h0000_0002, 32'hFFFF_FFFF, 32'h0000_0001, 33});
      vecs.push_back(vec_t'{MULHU,  32'h8000_0000, 32'h0000_0002, 32'h0000_0001, 33});
      vecs.push_back(vec_t'{DIV,    32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33});
      vecs.push_back(vec_t'{REM,    32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 33});
      vecs.push_back(vec_t'{DIVU,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 33});
      vecs.push_back(vec_t'{DIV,    32'h8000_0000, 32'h0000_0001, 32'h8000_0000, 33});

      rstn = 1'b0;
      start = 1'b0;
      flush = 1'b0;
      op = MUL;
      ALUData1 = '0;
      ALUData2 = '0;
      #1;
      check("reset busy", {31'd0, busy}, 32'd0);
      check("reset done", {31'd0, done}, 32'd0);
      check("reset result", result, 32'd0);
      repeat (3) @(negedge clk);
      rstn = 1'b1;

      // Odd entries launch from IDLE, even ones (after the first) from DONE.
      foreach (vecs[i]) begin
         if (i % 2 == 1) @(negedge clk);
         accept_op(vecs[i].op, vecs[i].a, vecs[i].b);
         wait_done(res, lat, bc);
         check($sformatf("vec%0d result", i), res, vecs[i].exp);
         check($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].lat));
         check($sformatf("vec%0d busy cycles", i), 32'(bc), 32'(vecs[i].lat));
      end

      // start during CALC is ignored
      @(negedge clk);
      accept_op(MUL, 32'd3, 32'd5);
      repeat (5) @(negedge clk);
      op = DIVU;
      ALUData1 = 32'd100;
      ALUData2 = 32'd7;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(res, lat, bc);
      check("busy-start result", res, 32'd15);
      check("busy-start latency", 32'(lat), 32'd27);
      @(negedge clk);
      check("busy-start no relaunch", {31'd0, busy}, 32'd0);

      // flush at iteration 10, then flush racing a start
      accept_op(DIVU, 32'd100, 32'd7);
      repeat (9) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush busy", {31'd0, busy}, 32'd0);
      check("flush done", {31'd0, done}, 32'd0);
      flush = 1'b1;
      start = 1'b1;
      op = MUL;
      ALUData1 = 32'd2;
      ALUData2 = 32'd2;
      @(negedge clk);
      flush = 1'b0;
      start = 1'b0;
      check("flush-over-start busy", {31'd0, busy}, 32'd0);
      count_idle(40, dc, bc);
      check("flush no done", 32'(dc), 32'd0);
      check("flush no busy", 32'(bc), 32'd0);
      check("flush result kept", result, 32'd15);

      // asynchronous reset mid-CALC
      accept_op(MUL, 32'h0000_0007, 32'hFFFF_FFFD);
      repeat (10) @(negedge clk);
      #2 rstn = 1'b0;
      #1;
      check("midreset busy", {31'd0, busy}, 32'd0);
      check("midreset done", {31'd0, done}, 32'd0);
      check("midreset result", result, 32'd0);
      @(negedge clk);
      rstn = 1'b1;
      count_idle(40, dc, bc);
      check("midreset no done", 32'(dc), 32'd0);
      check("midreset no busy", 32'(bc), 32'd0);

      // back-to-back: second start held during the first DONE cycle
      accept_op(DIVU, 32'd9, 32'd3);
      wait_done(res, lat, bc);
      check("b2b first result", res, 32'd3);
      check("b2b first latency", 32'(lat), 32'd33);
      accept_op(MUL, 32'd3, 32'd5);
      wait_done(res, lat, bc);
      check("b2b second result", res, 32'd15);
      check("b2b second latency", 32'(lat), 32'd33);
      @(negedge clk);
      check("b2b done one cycle", {31'd0, done}, 32'd0);
      check("b2b result held", result, 32'd15);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
